// File: rtl/cmt_pkg.sv
// Shared constants and types for the cassette (CMT) serial output block.
package cmt_pkg;

    // Register addresses; the data push and the status read share address 0.
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CLR    = 2'd3;

    // Status word bit positions; the FIFO count starts at ST_COUNT.
    localparam int ST_BUSY  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;

    // Control word bit positions.
    localparam int CTRL_MOTOR = 0;
    localparam int CTRL_TX_EN = 1;

    // 50 MHz / 1200 bit/s.
    localparam int DEFAULT_DIV = 41667;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

endpackage

// File: rtl/cmt_tx_out_if.sv
// Avalon-MM register bus seen by the CMT output block.
interface cmt_tx_out_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output write, output writedata, input readdata);
    modport slave  (input address, input write, input writedata, output readdata);
endinterface

// File: rtl/cmt_tx_fifo.sv
// Byte FIFO, first-word fall-through: the head is always visible on dout.
module cmt_tx_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    // Emptiness is judged before this cycle's push, so a push into an empty
    // FIFO cannot be popped in the same cycle.
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q];
    assign count   = cnt_q;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    // Pointers wrap naturally at 2^AW; the count is one bit wider so full is representable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cmt_tx_out.sv
// CMT output port: register file, FIFO and an 8-N-2 serializer driving cmt_txd.
module cmt_tx_out #(
    parameter int FIFO_AW     = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 41667
) (
    input  logic     clk,
    input  logic     reset,
    cmt_tx_out_if.slave bus,
    output logic     cmt_txd,
    output logic     cmt_motor
);
    import cmt_pkg::*;

    tx_state_e        state_q;
    logic [7:0]       shreg_q;
    logic [2:0]       idx_q;
    logic [DIV_W-1:0] cnt_q, div_q, bit_len_m1;
    logic             txd_q, motor_q, tx_en_q, ovf_q;
    logic [31:0]      readdata_d, readdata_q;
    logic             push_w, pop_w, last_stop;
    logic [7:0]       fifo_dout;
    logic             fifo_empty, fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic             unused_wd;

    assign unused_wd  = ^bus.writedata;
    assign push_w     = bus.write && (bus.address == ADDR_DATA);
    // Divisor values 0 and 1 both give a single clock per bit.
    assign bit_len_m1 = (div_q < DIV_W'(2)) ? '0 : div_q - DIV_W'(1);
    assign last_stop  = (state_q == STOP) && (cnt_q == '0) && idx_q[0];
    // Pops happen only from IDLE or at the very end of a frame, so disabling
    // tx_en mid-frame lets the current frame finish without fetching another.
    assign pop_w      = tx_en_q && !fifo_empty && ((state_q == IDLE) || last_stop);

    cmt_tx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_w),
        .pop   (pop_w),
        .din   (bus.writedata[7:0]),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Control, divisor and sticky overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motor_q <= 1'b0;
            tx_en_q <= 1'b0;
            div_q   <= DIV_W'(DEFAULT_DIV);
            ovf_q   <= 1'b0;
        end else begin
            if (bus.write) begin
                case (bus.address)
                    ADDR_CTRL: begin
                        motor_q <= bus.writedata[CTRL_MOTOR];
                        tx_en_q <= bus.writedata[CTRL_TX_EN];
                    end
                    ADDR_DIV: div_q <= bus.writedata[DIV_W-1:0];
                    ADDR_CLR: ovf_q <= 1'b0;
                    default: ;
                endcase
            end
            if (push_w && fifo_full && !pop_w) ovf_q <= 1'b1;
        end
    end

    // Read mux for the registered read port.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_STATUS: begin
                readdata_d[ST_BUSY]  = (state_q != IDLE);
                readdata_d[ST_EMPTY] = fifo_empty;
                readdata_d[ST_FULL]  = fifo_full;
                readdata_d[ST_OVF]   = ovf_q;
                readdata_d[ST_COUNT +: FIFO_AW+1] = fifo_count;
            end
            ADDR_CTRL: begin
                readdata_d[CTRL_MOTOR] = motor_q;
                readdata_d[CTRL_TX_EN] = tx_en_q;
            end
            ADDR_DIV: readdata_d[DIV_W-1:0] = div_q;
            default:  readdata_d = '0;
        endcase
    end

    // Read data is sampled every cycle; no read strobe is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata_q <= '0;
        else       readdata_q <= readdata_d;
    end

    // Serializer: the line level is registered from the current state, so
    // cmt_txd trails the state by one clock; idx_q doubles as the stop-bit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= shreg_q[idx_q];
                default: txd_q <= 1'b1;
            endcase
            case (state_q)
                IDLE: begin
                    if (pop_w) begin
                        shreg_q <= fifo_dout;
                        state_q <= START;
                        cnt_q   <= bit_len_m1;
                        idx_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        cnt_q   <= bit_len_m1;
                    end else cnt_q <= cnt_q - 1'b1;
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= bit_len_m1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            idx_q   <= '0;
                        end else idx_q <= idx_q + 1'b1;
                    end else cnt_q <= cnt_q - 1'b1;
                end
                STOP: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else if (!idx_q[0]) begin
                        idx_q <= 3'd1;
                        cnt_q <= bit_len_m1;
                    end else if (pop_w) begin
                        shreg_q <= fifo_dout;
                        state_q <= START;
                        cnt_q   <= bit_len_m1;
                        idx_q   <= '0;
                    end else state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.readdata = readdata_q;
    assign cmt_txd      = txd_q;
    assign cmt_motor    = motor_q;
endmodule

// File: doc/cmt_tx_out.md
# cmt_tx_out

Avalon-MM write-side cassette (CMT) interface: the output counterpart of the CMT GPIO input port. The CPU pushes bytes into a 16-entry FIFO, and a serializer shifts them out on `cmt_txd` as asynchronous 8-N-2 frames at a programmable bit period. The block also drives the cassette motor relay. It sits on the same Avalon bus segment as the CMT input PIO, and `cmt_txd` feeds the tape modulator.

## Interface
Parameters:
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW.
- `DIV_W`, 16: bit-period divisor width.
- `DEFAULT_DIV`, 41667: reset divisor (50 MHz / 1200 bit/s).

Ports:
- `clk`  in  1  system clock; the only clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  2  register select.
- `write`  in  1  write strobe, single cycle.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `cmt_txd`  out  1  serial data; idles high.
- `cmt_motor`  out  1  motor relay enable.

## Operation
Register map (readdata is always {zero-pad, field}):
- addr 0 write: push `writedata[7:0]`.
  - A push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- addr 0 read: status.
  - bit0 `busy` (state ≠ IDLE), bit1 `empty`, bit2 `full`, bit3 `overflow`.
  - bits[8+FIFO_AW:8] FIFO count.
- addr 1 read/write: control. bit0 `motor` (drives `cmt_motor`), bit1 `tx_en`. Other bits read 0.
- addr 2 read/write: divisor [DIV_W-1:0].
  - 0 and 1 both mean one clock per bit.
  - The divisor is latched at the start of each bit; a change takes effect at the next bit boundary.
- addr 3 write: any write clears `overflow`. Reads return 0.

Serializer FSM: IDLE → START → DATA → STOP → IDLE.
- IDLE: when `tx_en`=1 and FIFO non-empty, pop the head into the shift register and go to START on the next edge.
- START: `cmt_txd`=0 for one bit period.
- DATA: 8 bits, LSB first, one bit period each; a 3-bit index counts 0..7.
- STOP: `cmt_txd`=1 for two bit periods.
  - Then, if `tx_en`=1 and FIFO non-empty, pop and go directly to START, giving back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- Clearing `tx_en` mid-frame finishes the current frame. No further pops occur.
- `cmt_motor` is independent of the FSM.

Reset values: `readdata`=0, `cmt_txd`=1, `cmt_motor`=0, `tx_en`=0, divisor=`DEFAULT_DIV`, FIFO empty, `overflow`=0, state IDLE. Reset asserted mid-frame aborts the frame immediately and discards the FIFO contents.

## Timing
- `readdata` is registered every cycle from `address`: valid one cycle after the address is presented. No read strobe.
- Register writes take effect at the clock edge where `write`=1. FIFO count updates the next cycle.
- With the block idle and enabled, a push at edge N pops at edge N+1, and `cmt_txd` falls at edge N+2.
- Frame length is exactly 11 × divisor clocks.
- Bit-period counter: loads divisor−1 at each bit start, counts down, and advances on 0.
- Pointers wrap modulo 2^FIFO_AW. Count is FIFO_AW+1 bits wide, so full is representable.
- Simultaneous push and pop on a full FIFO: both happen, count is unchanged, no overflow.
- Simultaneous push and pop on an empty FIFO: the pop is suppressed because `empty` is evaluated before the push.

## Structure
- Package `cmt_pkg`:
  - register address constants (ADDR_DATA/STATUS, CTRL, DIV, CLR);
  - status bit indices;
  - FSM state enum (IDLE, START, DATA, STOP);
  - `DEFAULT_DIV`.
- Sub-module `cmt_tx_fifo`: synchronous FIFO. Ports: push, pop, din[7:0], dout[7:0], empty, full, count. Head is shown on `dout` (first-word fall-through).
- Top level holds the register file, read mux, serializer FSM and bit-period counter.

## Test plan
- Reset values: after reset, read addr 0 → 0x0002, addr 2 → 41667. `cmt_txd`=1, `cmt_motor`=0.
- Single frame: divisor=4, write 0xA5, `tx_en`=1.
  - `cmt_txd` sequence per 4 clocks: 0,1,0,1,0,0,1,0,1,1,1.
  - `busy` clears after 44 clocks.
- Back-to-back and overflow, divisor=1:
  - Write 17 bytes with `tx_en`=0. Count=16, `full`=1, `overflow`=1.
  - Write addr 3: overflow clears.
  - Enable: 16 contiguous frames, 176 clocks, no idle gaps.
- Full-with-pop: with the FIFO full and a pop occurring, a push in the same cycle is accepted. Count stays 16, `overflow` stays 0.
- Mid-frame events:
  - Clear `tx_en` during DATA: the frame completes, then IDLE.
  - Change divisor 4→2 mid-bit: the next bit lasts 2 clocks.
  - Assert `reset` mid-frame: `cmt_txd`=1 immediately and the FIFO empties.
- Motor: write addr 1 = 0x1 → `cmt_motor`=1 the next cycle. Read addr 1 → 0x1.
